pipeline_stall_ctrl: RTL and testbench



---
 rtl/pipeline_pkg.sv | 62 ++++++
 rtl/pipeline_stall_ctrl_mem_wait_timer.sv | 40 ++++
 rtl/pipeline_stall_ctrl.sv | 100 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// State encoding, control bundle and hazard helper.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'h00;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{
        stall_f: 1'b0, stall_d: 1'b0,
        stall_e: 1'b0, stall_m: 1'b0,
        flush_d: 1'b0, flush_e: 1'b0,
        flush_w: 1'b0
    };

    // Freeze F..M and bubble WB so the stalled load never retires twice.
    localparam ctrl_t CTRL_MEM = '{
        stall_f: 1'b1, stall_d: 1'b1,
        stall_e: 1'b1, stall_m: 1'b1,
        flush_d: 1'b0, flush_e: 1'b0,
        flush_w: 1'b1
    };

    localparam ctrl_t CTRL_BRANCH = '{
        stall_f: 1'b0, stall_d: 1'b0,
        stall_e: 1'b0, stall_m: 1'b0,
        flush_d: 1'b1, flush_e: 1'b1,
        flush_w: 1'b0
    };

    localparam ctrl_t CTRL_LOADUSE = '{
        stall_f: 1'b1, stall_d: 1'b1,
        stall_e: 1'b0, stall_m: 1'b0,
        flush_d: 1'b0, flush_e: 1'b1,
        flush_w: 1'b0
    };

    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return mem_read & (rd != REG_ZERO)
             & ((rd == rs1) | (rd == rs2));
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_mem_wait_timer.sv
// Counts consecutive data-memory wait cycles.
// Raises a sticky error once the wait outlives TIMEOUT.
module mem_wait_timer
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hold,
    output logic expired,
    output logic mem_err
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    logic [TO_W-1:0] cnt;

    assign expired = hold & (cnt == TO_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            mem_err <= 1'b0;
        end else if (start) begin
            cnt <= TO_ONE;
        end else if (expired) begin
            cnt     <= '0;
            mem_err <= 1'b1;
        end else if (hold) begin
            cnt <= cnt + TO_ONE;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use,
// taken-branch redirect and data-memory wait with timeout.
module pipeline_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = $clog2(TIMEOUT + 1),
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemReadEx,
    input  logic [4:0]       RD_Ex,
    input  logic [4:0]       RS1D,
    input  logic [4:0]       RS2D,
    input  logic             PCSrcEx,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt
);

    state_t state;
    ctrl_t  ctrl;
    logic   memstall;
    logic   loaduse;
    logic   expired;

    assign memstall = MemReqM & ~MemReadyM;
    assign loaduse  = load_use(MemReadEx, RD_Ex, RS1D, RS2D);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   ((state == RUN) & memstall),
        .hold    ((state == MEM_WAIT) & memstall),
        .expired (expired),
        .mem_err (MemErr)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (memstall)
                        state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (!memstall)
                        state <= RUN;
                    else if (expired)
                        state <= ERROR;
                end
                ERROR:   state <= ERROR;
                default: state <= RUN;
            endcase
        end
    end

    // Memory wait outranks a branch so the redirect is replayed on release.
    always_comb begin
        ctrl = CTRL_NONE;
        if (!rst)
            ctrl = CTRL_NONE;
        else if ((state == ERROR) | memstall)
            ctrl = CTRL_MEM;
        else if (PCSrcEx)
            ctrl = CTRL_BRANCH;
        else if (loaduse)
            ctrl = CTRL_LOADUSE;
    end

    assign StallF = ctrl.stall_f;
    assign StallD = ctrl.stall_d;
    assign StallE = ctrl.stall_e;
    assign StallM = ctrl.stall_m;
    assign FlushD = ctrl.flush_d;
    assign FlushE = ctrl.flush_e;
    assign FlushW = ctrl.flush_w;

    always_ff @(posedge clk) begin
        if (!rst)
            StallCnt <= '0;
        else if (ctrl.stall_f && (StallCnt != '1))
            StallCnt <= StallCnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed and random checks of pipeline_stall_ctrl against
// a cycle-level behavioural model of the hazard rules.
module tb_pipeline_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             MemReadEx;
    logic [4:0]       RD_Ex, RS1D, RS2D;
    logic             PCSrcEx, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW, MemErr;
    logic [CNT_W-1:0] StallCnt;

    int vectors = 0;
    int errors  = 0;

    // Model state: error flag, consecutive wait length, stall count.
    bit m_err  = 1'b0;
    int m_run  = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemReadEx (MemReadEx),
        .RD_Ex     (RD_Ex),
        .RS1D      (RS1D),
        .RS2D      (RS2D),
        .PCSrcEx   (PCSrcEx),
        .MemReqM   (MemReqM),
        .MemReadyM (MemReadyM),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .StallM    (StallM),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .FlushW    (FlushW),
        .MemErr    (MemErr),
        .StallCnt  (StallCnt)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic mr,
                         input logic [4:0] rd,
                         input logic [4:0] s1,
                         input logic [4:0] s2,
                         input logic pc, input logic rq,
                         input logic ry);
        rst = r; MemReadEx = mr; RD_Ex = rd;
        RS1D = s1; RS2D = s2; PCSrcEx = pc;
        MemReqM = rq; MemReadyM = ry;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        bit ms, lu, stall4, br, lus;
        logic [6:0] exp_o;
        ms  = MemReqM && !MemReadyM;
        lu  = MemReadEx && RD_Ex != 0 &&
              (RD_Ex == RS1D || RD_Ex == RS2D);
        stall4 = rst && (m_err || ms);
        br     = rst && !stall4 && PCSrcEx;
        lus    = rst && !stall4 && !PCSrcEx && lu;
        exp_o = {stall4 || lus, stall4 || lus, stall4,
                 stall4, br, br || lus, stall4};
        chk("outputs",
            {25'd0, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW},
            {25'd0, exp_o});
        chk("MemErr", {31'd0, MemErr}, {31'd0, m_err});
        chk("StallCnt", 32'(StallCnt), 32'(m_cnt));
        if (!rst) begin
            m_err = 0; m_run = 0; m_cnt = 0;
        end else begin
            if (exp_o[6] && m_cnt < CNT_MAX) m_cnt++;
            if (!m_err) begin
                if (ms) begin
                    m_run++;
                    if (m_run == TIMEOUT + 1) m_err = 1;
                end else begin
                    m_run = 0;
                end
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick; tick;
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("rst_gates_stall", {31'd0, StallF}, 0);
        tick;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_cnt", 32'(StallCnt), 0);
        chk("rst_err", {31'd0, MemErr}, 0);

        drive(1, 1, 5, 0, 5, 0, 0, 0);
        chk("lu_stallf", {31'd0, StallF}, 1);
        chk("lu_stalld", {31'd0, StallD}, 1);
        chk("lu_flushe", {31'd0, FlushE}, 1);
        chk("lu_stalle", {31'd0, StallE}, 0);
        tick;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_release", {31'd0, StallF}, 0);
        chk("lu_cnt", 32'(StallCnt), 1);

        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("lu_r0", {31'd0, StallF}, 0);
        drive(1, 1, 5, 0, 5, 1, 0, 0);
        chk("br_flushd", {31'd0, FlushD}, 1);
        chk("br_flushe", {31'd0, FlushE}, 1);
        chk("br_nostall", {31'd0, StallF}, 0);
        tick;

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 0);
            chk("mw_stallm", {31'd0, StallM}, 1);
            chk("mw_flushw", {31'd0, FlushW}, 1);
            tick;
        end
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        chk("mw_ready", {31'd0, StallF}, 0);
        chk("mw_ready_w", {31'd0, FlushW}, 0);
        tick;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("mw_cnt", 32'(StallCnt), 3);

        drive(1, 0, 0, 0, 0, 1, 1, 0);
        chk("bw_noflush", {31'd0, FlushD}, 0);
        chk("bw_stall", {31'd0, StallF}, 1);
        tick;
        drive(1, 0, 0, 0, 0, 1, 1, 1);
        chk("bw_flushd", {31'd0, FlushD}, 1);
        chk("bw_flushe", {31'd0, FlushE}, 1);
        chk("bw_release", {31'd0, StallF}, 0);
        tick;

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        for (int i = 0; i < TIMEOUT + 1; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 0);
            chk("to_noerr", {31'd0, MemErr}, 0);
            tick;
        end
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        chk("to_err", {31'd0, MemErr}, 1);
        chk("to_stuck", {31'd0, StallF}, 1);
        chk("to_stuck_w", {31'd0, FlushW}, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 3, 3, 0, 1, 0, 1);
            tick;
        end
        chk("sat_cnt", 32'(StallCnt), 7);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("err_rst_comb", {31'd0, StallF}, 0);
        tick;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("err_rst_err", {31'd0, MemErr}, 0);
        chk("err_rst_cnt", 32'(StallCnt), 0);
        chk("err_rst_out", {31'd0, StallF}, 0);
        tick;

        for (int i = 0; i < 3000; i++) begin
            bit slow;
            slow = (i / 200) % 2 == 1;
            drive(($urandom % 97) != 0,
                  ($urandom % 3) == 0,
                  5'($urandom % 4),
                  5'($urandom % 4),
                  5'($urandom % 4),
                  ($urandom % 6) == 0,
                  slow ? ($urandom % 4) != 0
                       : ($urandom % 3) == 0,
                  slow ? ($urandom % 10) == 0
                       : ($urandom % 2) == 0);
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
